// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per clock, single-cycle register-file write-back strobe.
module mul_div_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [ADDR_WIDTH-1:0] destAddress,
   input  logic [DATA_WIDTH-1:0] operandA,
   input  logic [DATA_WIDTH-1:0] operandB,
   output logic                  busy,
   output logic                  writeRegister,
   output logic [ADDR_WIDTH-1:0] writeAddress,
   output logic [DATA_WIDTH-1:0] writeData
);

   localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [1:0]            op_q, op_d;
   logic [ADDR_WIDTH-1:0] dest_q, dest_d;
   logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
   logic [DATA_WIDTH:0]   acc_q, acc_d;
   logic [DATA_WIDTH-1:0] low_q, low_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic [DATA_WIDTH:0]   mul_sum;
   logic [DATA_WIDTH:0]   mul_add;
   logic [DATA_WIDTH:0]   div_shift;

   // acc holds the product high half (multiply) or partial remainder (divide);
   // low holds the multiplier being consumed or the dividend turning into the quotient.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      dest_d    = dest_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      low_d     = low_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;

      mul_sum   = {1'b0, acc_q[DATA_WIDTH-1:0]} + {1'b0, opnd_q};
      mul_add   = low_q[0] ? mul_sum : {1'b0, acc_q[DATA_WIDTH-1:0]};
      div_shift = {acc_q[DATA_WIDTH-1:0], low_q[DATA_WIDTH-1]};

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op;
               dest_d  = destAddress;
               acc_d   = '0;
               count_d = '0;
               if (op[1]) begin
                  low_d  = operandA;
                  opnd_d = operandB;
               end else begin
                  low_d  = operandB;
                  opnd_d = operandA;
               end
               state_d = RUN;
            end
         end
         RUN: begin
            count_d = count_q + 1'b1;
            if (!op_q[1]) begin
               acc_d = {1'b0, mul_add[DATA_WIDTH:1]};
               low_d = {mul_add[0], low_q[DATA_WIDTH-1:1]};
            end else if (div_shift >= {1'b0, opnd_q}) begin
               // A zero divisor always subtracts: quotient all ones, remainder = dividend.
               acc_d = div_shift - {1'b0, opnd_q};
               low_d = {low_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
               acc_d = div_shift;
               low_d = {low_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (count_q == LAST) begin
               state_d = DONE;
               waddr_d = dest_q;
               wdata_d = op_q[0] ? acc_d[DATA_WIDTH-1:0] : low_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         count_q <= '0;
         op_q    <= '0;
         dest_q  <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         low_q   <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         dest_q  <= dest_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         low_q   <= low_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign writeRegister = (state_q == DONE);
   assign writeAddress  = waddr_q;
   assign writeData     = wdata_q;

endmodule
